vga_fb_arbiter: RTL and testbench

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_pixel_shifter.sv | 85 ++++++++
 rtl/vga_fb_arbiter.sv | 94 +++++++++
 tb/tb_vga_fb_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and command-state encoding for the VGA framebuffer arbiter.
// Display geometry defaults, pixel packing and the fixed pixel pipeline latency.
package vga_pkg;

    localparam int H_ACTIVE       = 480;
    localparam int V_ACTIVE       = 272;
    localparam int PIX_W          = 4;
    localparam int PIX_PER_WORD   = 4;
    localparam int WORD_W         = PIX_W * PIX_PER_WORD;
    localparam int WORDS_PER_LINE = H_ACTIVE / PIX_PER_WORD;

    // Column of a pixel to its appearance on pixel_o, in clock cycles.
    localparam int PIXEL_LATENCY  = 3;

    typedef enum logic [1:0] {
        CMD_IDLE    = 2'd0,
        CMD_DISP_RD = 2'd1,
        CMD_WRITE   = 2'd2
    } cmd_state_t;

    // Words per line for an arbitrary active width (parameter overrides).
    function automatic int words_per_line(input int hactive);
        return hactive / PIX_PER_WORD;
    endfunction

endpackage

// File: rtl/vga_pixel_shifter.sv
// Turns one 16-bit framebuffer word into four consecutive 4-bit pixels, with a
// per-lane valid flag so pixel_o is forced to zero outside display-sourced pixels.
module vga_pixel_shifter
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              srst,
    input  logic              disp_rd,
    input  logic [WORD_W-1:0] rdata,
    output logic [PIX_W-1:0]  pixel,
    output logic              pixel_valid
);

    // Cycles between the read command on the RAM port and the word being loaded.
    localparam int LOAD_DELAY = PIXEL_LATENCY - 2;

    logic             load_pipe_reg  [LOAD_DELAY];
    logic [PIX_W-1:0] lane_reg       [PIX_PER_WORD];
    logic             lane_valid_reg [PIX_PER_WORD];
    logic             load_now;

    genvar gi;

    generate
        for (gi = 0; gi < LOAD_DELAY; gi++) begin : g_load_pipe
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (srst) begin
                        load_pipe_reg[gi] <= 1'b0;
                    end else begin
                        load_pipe_reg[gi] <= disp_rd;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (srst) begin
                        load_pipe_reg[gi] <= 1'b0;
                    end else begin
                        load_pipe_reg[gi] <= load_pipe_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign load_now = load_pipe_reg[LOAD_DELAY-1];

    // Lane 0 drives the DAC; each lane takes its neighbour's pixel on a shift,
    // and a fresh load always overrides whatever is still being shifted out.
    generate
        for (gi = 0; gi < PIX_PER_WORD; gi++) begin : g_lane
            if (gi == PIX_PER_WORD - 1) begin : g_top
                always_ff @(posedge clk) begin
                    if (srst) begin
                        lane_reg[gi]       <= '0;
                        lane_valid_reg[gi] <= 1'b0;
                    end else if (load_now) begin
                        lane_reg[gi]       <= rdata[gi*PIX_W +: PIX_W];
                        lane_valid_reg[gi] <= 1'b1;
                    end else begin
                        lane_reg[gi]       <= '0;
                        lane_valid_reg[gi] <= 1'b0;
                    end
                end
            end else begin : g_mid
                always_ff @(posedge clk) begin
                    if (srst) begin
                        lane_reg[gi]       <= '0;
                        lane_valid_reg[gi] <= 1'b0;
                    end else if (load_now) begin
                        lane_reg[gi]       <= rdata[gi*PIX_W +: PIX_W];
                        lane_valid_reg[gi] <= 1'b1;
                    end else begin
                        lane_reg[gi]       <= lane_reg[gi+1];
                        lane_valid_reg[gi] <= lane_valid_reg[gi+1];
                    end
                end
            end
        end
    endgenerate

    assign pixel_valid = lane_valid_reg[0];
    assign pixel       = lane_valid_reg[0] ? lane_reg[0] : '0;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display reads own every 4th active column,
// writer requests fill the remaining cycles, read words are serialised to pixels.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int HACTIVE = H_ACTIVE,
    parameter int VACTIVE = V_ACTIVE,
    parameter int AW      = 15
) (
    input  logic              pxclk_i,
    input  logic              rst_i,
    input  logic              hactive_i,
    input  logic              vactive_i,
    input  logic [11:0]       col_i,
    input  logic [11:0]       row_i,
    input  logic              wr_req_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [WORD_W-1:0] wr_data_i,
    output logic              wr_ack_o,
    output logic [AW-1:0]     ram_addr_o,
    output logic              ram_we_o,
    output logic [WORD_W-1:0] ram_wdata_o,
    input  logic [WORD_W-1:0] ram_rdata_i,
    output logic [PIX_W-1:0]  pixel_o,
    output logic              pixel_valid_o
);

    localparam logic [11:0]   HACT_LIM = 12'(HACTIVE);
    localparam logic [11:0]   VACT_LIM = 12'(VACTIVE);
    localparam logic [AW-1:0] WPL      = AW'(words_per_line(HACTIVE));

    cmd_state_t        state_reg;
    logic [AW-1:0]     ram_addr_reg;
    logic              ram_we_reg;
    logic [WORD_W-1:0] ram_wdata_reg;
    logic              wr_ack_reg;

    logic              disp_slot;
    logic              wr_grant;
    logic              disp_rd;
    logic [AW-1:0]     rd_addr;

    // Range checks matter: the timing generator may leave its active flags
    // high past the visible area, and those columns must not touch the RAM.
    assign disp_slot = hactive_i & vactive_i & (col_i[1:0] == 2'b00)
                     & (col_i < HACT_LIM) & (row_i < VACT_LIM);

    assign rd_addr   = AW'(row_i) * WPL + AW'(col_i[11:2]);

    // A cycle showing an ack cannot accept, which paces writes to one per two cycles.
    assign wr_grant  = ~disp_slot & wr_req_i & ~wr_ack_reg;

    always_ff @(posedge pxclk_i) begin
        if (rst_i) begin
            state_reg     <= CMD_IDLE;
            ram_addr_reg  <= '0;
            ram_we_reg    <= 1'b0;
            ram_wdata_reg <= '0;
            wr_ack_reg    <= 1'b0;
        end else if (disp_slot) begin
            state_reg     <= CMD_DISP_RD;
            ram_addr_reg  <= rd_addr;
            ram_we_reg    <= 1'b0;
            wr_ack_reg    <= 1'b0;
        end else if (wr_grant) begin
            state_reg     <= CMD_WRITE;
            ram_addr_reg  <= wr_addr_i;
            ram_we_reg    <= 1'b1;
            ram_wdata_reg <= wr_data_i;
            wr_ack_reg    <= 1'b1;
        end else begin
            state_reg     <= CMD_IDLE;
            ram_we_reg    <= 1'b0;
            wr_ack_reg    <= 1'b0;
        end
    end

    assign disp_rd     = (state_reg == CMD_DISP_RD);

    assign ram_addr_o  = ram_addr_reg;
    assign ram_we_o    = ram_we_reg;
    assign ram_wdata_o = ram_wdata_reg;
    assign wr_ack_o    = wr_ack_reg;

    vga_pixel_shifter u_shifter (
        .clk         (pxclk_i),
        .srst        (rst_i),
        .disp_rd     (disp_rd),
        .rdata       (ram_rdata_i),
        .pixel       (pixel_o),
        .pixel_valid (pixel_valid_o)
    );

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed scenarios plus a randomized scan checked
// against a history-based reference model and a behavioural RAM.
module tb_vga_fb_arbiter;

    localparam int H    = 480;
    localparam int V    = 272;
    localparam int WPL  = H / 4;
    localparam int HIST = 8192;

    logic        pxclk = 1'b0;
    logic        rst = 1'b1;
    logic        hactive = 1'b0;
    logic        vactive = 1'b0;
    logic [11:0] col = '0;
    logic [11:0] row = '0;
    logic        wr_req = 1'b0;
    logic [14:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] ram_rdata = '0;
    logic        wr_ack;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [3:0]  pixel;
    logic        pixel_valid;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: per-cycle history plus the expected registered outputs.
    int          cyc = 0;
    bit          slot_hist [HIST];
    bit          rst_hist  [HIST];
    logic [15:0] word_hist [HIST];
    logic [14:0] exp_addr  = '0;
    bit          exp_we    = 1'b0;
    bit          exp_ack   = 1'b0;
    logic [15:0] exp_wdata = '0;
    bit          exp_pv    = 1'b0;
    logic [3:0]  exp_pix   = '0;

    vga_fb_arbiter #(.HACTIVE(480), .VACTIVE(272), .AW(15)) dut (
        .pxclk_i       (pxclk),
        .rst_i         (rst),
        .hactive_i     (hactive),
        .vactive_i     (vactive),
        .col_i         (col),
        .row_i         (row),
        .wr_req_i      (wr_req),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .wr_ack_o      (wr_ack),
        .ram_addr_o    (ram_addr),
        .ram_we_o      (ram_we),
        .ram_wdata_o   (ram_wdata),
        .ram_rdata_i   (ram_rdata),
        .pixel_o       (pixel),
        .pixel_valid_o (pixel_valid)
    );

    always #5 pxclk = ~pxclk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Framebuffer contents seen by the bench; address 0 holds 0x4321.
    function automatic logic [15:0] mem_word(input logic [14:0] a);
        logic [31:0] p;
        p = 32'(a) * 32'h0000_9E37;
        return p[15:0] ^ 16'h4321;
    endfunction

    function automatic logic [14:0] read_addr(input logic [11:0] c, input logic [11:0] r);
        int ci;
        int ri;
        ci = int'(c);
        ri = int'(r);
        return 15'((ri * WPL + ci / 4) % 32768);
    endfunction

    function automatic bit slot_rule(input logic h, input logic v, input logic [11:0] c,
                                     input logic [11:0] r);
        int ci;
        int ri;
        ci = int'(c);
        ri = int'(r);
        return h && v && (ci % 4 == 0) && ci < H && ri < V;
    endfunction

    task automatic drive(input bit h, input bit v, input int c, input int r);
        hactive = h;
        vactive = v;
        col     = 12'(c);
        row     = 12'(r);
    endtask

    // Advance one clock; update the RAM model and the expected outputs.
    task automatic tick();
        bit          s;
        bit          acc;
        bit          alive;
        int          src;
        int          k;
        logic [14:0] cur_addr;
        logic [14:0] n_addr;
        logic [15:0] n_wdata;
        logic [15:0] w;
        if (cyc >= HIST - 1) begin
            $display("FAIL history: cycle budget exceeded at cycle %0d", cyc);
            $fatal(1, "history overflow");
        end
        s   = !rst && slot_rule(hactive, vactive, col, row);
        acc = !rst && !s && wr_req && !exp_ack;
        rst_hist[cyc]  = rst;
        slot_hist[cyc] = s;
        word_hist[cyc] = mem_word(read_addr(col, row));
        if (rst) begin
            n_addr  = '0;
            n_wdata = '0;
        end else if (s) begin
            n_addr  = read_addr(col, row);
            n_wdata = exp_wdata;
        end else if (acc) begin
            n_addr  = wr_addr;
            n_wdata = wr_data;
        end else begin
            n_addr  = exp_addr;
            n_wdata = exp_wdata;
        end
        cur_addr = ram_addr;
        @(posedge pxclk);
        #1;
        cyc++;
        ram_rdata = mem_word(cur_addr);
        exp_addr  = n_addr;
        exp_wdata = n_wdata;
        exp_we    = acc;
        exp_ack   = acc;
        // Pixel k of a word fetched by the slot at cycle src shows at src+3+k.
        exp_pv  = 1'b0;
        exp_pix = '0;
        src = -1;
        for (int s2 = cyc - 3; s2 >= cyc - 6; s2--) begin
            if (s2 >= 0 && src < 0 && slot_hist[s2]) src = s2;
        end
        if (src >= 0) begin
            alive = 1'b1;
            for (int c2 = src; c2 < cyc; c2++) begin
                if (rst_hist[c2]) alive = 1'b0;
            end
            if (alive) begin
                k       = cyc - 3 - src;
                w       = word_hist[src];
                exp_pv  = 1'b1;
                exp_pix = w[4*k +: 4];
            end
        end
    endtask

    task automatic test_reset();
        drive(1, 1, 0, 0);
        wr_req  = 1'b1;
        wr_addr = 15'h0123;
        wr_data = 16'hA5A5;
        rst     = 1'b1;
        for (int n = 0; n < 2; n++) begin
            tick();
            tests_run += 7;
            if (ram_we !== 1'b0) begin tests_failed++; $display("FAIL reset_we got=%b want=0", ram_we); end
            if (ram_addr !== 15'h0) begin tests_failed++; $display("FAIL reset_addr got=%h want=0", ram_addr); end
            if (ram_wdata !== 16'h0) begin tests_failed++; $display("FAIL reset_wdata got=%h want=0", ram_wdata); end
            if (wr_ack !== 1'b0) begin tests_failed++; $display("FAIL reset_ack got=%b want=0", wr_ack); end
            if (pixel !== 4'h0) begin tests_failed++; $display("FAIL reset_pixel got=%h want=0", pixel); end
            if (pixel_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_pv got=%b want=0", pixel_valid); end
            if (dut.state_reg !== vga_pkg::CMD_IDLE) begin tests_failed++; $display("FAIL reset_state got=%0d want=IDLE", dut.state_reg); end
        end
        rst    = 1'b0;
        wr_req = 1'b0;
        drive(0, 0, 0, 0);
        tick();
        $display("[TB] test_reset done at cycle %0d", cyc);
    endtask

    task automatic test_first_read();
        drive(1, 1, 0, 0);
        tick();
        tests_run += 2;
        if (ram_addr !== 15'd0) begin tests_failed++; $display("FAIL first_rd_addr got=%0d want=0", ram_addr); end
        if (ram_we !== 1'b0) begin tests_failed++; $display("FAIL first_rd_we got=%b want=0", ram_we); end
        for (int n = 1; n <= 6; n++) begin
            if (n <= 3) drive(1, 1, n, 0);
            else drive(0, 0, 0, 0);
            tick();
            if (n + 1 >= 3 && n + 1 <= 6) begin
                tests_run += 2;
                if (pixel !== 4'(n - 1)) begin tests_failed++; $display("FAIL first_rd_pix t=%0d got=%h want=%h", n + 1, pixel, 4'(n - 1)); end
                if (pixel_valid !== 1'b1) begin tests_failed++; $display("FAIL first_rd_pv t=%0d got=%b want=1", n + 1, pixel_valid); end
            end else if (n + 1 == 7) begin
                tests_run += 2;
                if (pixel !== 4'h0) begin tests_failed++; $display("FAIL first_rd_tail_pix got=%h want=0", pixel); end
                if (pixel_valid !== 1'b0) begin tests_failed++; $display("FAIL first_rd_tail_pv got=%b want=0", pixel_valid); end
            end
        end
        $display("[TB] test_first_read done at cycle %0d", cyc);
    endtask

    task automatic test_row_col_addr();
        drive(1, 1, 8, 5);
        tick();
        tests_run += 2;
        // Row 5 of 120 words per line, column 8 is word 2 of that line.
        if (ram_addr !== 15'd602) begin tests_failed++; $display("FAIL rowcol_addr got=%0d want=602", ram_addr); end
        if (ram_we !== 1'b0) begin tests_failed++; $display("FAIL rowcol_we got=%b want=0", ram_we); end
        drive(0, 0, 0, 0);
        for (int n = 0; n < 6; n++) tick();
        $display("[TB] test_row_col_addr done at cycle %0d", cyc);
    endtask

    task automatic test_write_vs_slot();
        int acks;
        int wes;
        acks = 0;
        wes  = 0;
        for (int c = 1; c <= 3; c++) begin
            drive(1, 1, c, 0);
            tick();
        end
        // The request first appears in the display slot of column 4.
        wr_req  = 1'b1;
        wr_addr = 15'h0100;
        wr_data = 16'hBEEF;
        for (int c = 4; c <= 9; c++) begin
            drive(1, 1, c, 0);
            tick();
            if (wr_ack === 1'b1) acks++;
            if (ram_we === 1'b1) wes++;
            if (c == 4) begin
                tests_run += 3;
                if (ram_we !== 1'b0) begin tests_failed++; $display("FAIL wvs_slot_we got=%b want=0", ram_we); end
                if (ram_addr !== 15'd1) begin tests_failed++; $display("FAIL wvs_slot_addr got=%0d want=1", ram_addr); end
                if (wr_ack !== 1'b0) begin tests_failed++; $display("FAIL wvs_slot_ack got=%b want=0", wr_ack); end
            end else if (c == 5) begin
                tests_run += 4;
                if (ram_we !== 1'b1) begin tests_failed++; $display("FAIL wvs_we got=%b want=1", ram_we); end
                if (ram_addr !== 15'h0100) begin tests_failed++; $display("FAIL wvs_addr got=%h want=0100", ram_addr); end
                if (ram_wdata !== 16'hBEEF) begin tests_failed++; $display("FAIL wvs_wdata got=%h want=BEEF", ram_wdata); end
                if (wr_ack !== 1'b1) begin tests_failed++; $display("FAIL wvs_ack got=%b want=1", wr_ack); end
            end
            if (wr_ack === 1'b1) wr_req = 1'b0;
        end
        tests_run += 2;
        if (acks != 1) begin tests_failed++; $display("FAIL wvs_ack_count got=%0d want=1", acks); end
        if (wes != 1) begin tests_failed++; $display("FAIL wvs_we_count got=%0d want=1", wes); end
        wr_req = 1'b0;
        drive(0, 0, 0, 0);
        for (int n = 0; n < 6; n++) tick();
        $display("[TB] test_write_vs_slot done at cycle %0d", cyc);
    endtask

    task automatic test_back_to_back();
        int  acks;
        bit  prev_ack;
        acks     = 0;
        prev_ack = 1'b0;
        drive(0, 0, 0, 0);
        wr_req  = 1'b1;
        wr_addr = 15'h0042;
        wr_data = 16'h0F0F;
        for (int n = 1; n <= 12; n++) begin
            tick();
            tests_run += 2;
            if (wr_ack !== 1'(n % 2)) begin tests_failed++; $display("FAIL b2b_ack n=%0d got=%b want=%b", n, wr_ack, 1'(n % 2)); end
            if (prev_ack && wr_ack === 1'b1) begin tests_failed++; $display("FAIL b2b_consecutive n=%0d got=1 want=0", n); end
            if (wr_ack === 1'b1) acks++;
            prev_ack = (wr_ack === 1'b1);
        end
        tests_run++;
        if (acks != 6) begin tests_failed++; $display("FAIL b2b_ack_count got=%0d want=6", acks); end
        wr_req = 1'b0;
        tick();
        tick();
        $display("[TB] test_back_to_back done at cycle %0d", cyc);
    endtask

    task automatic test_out_of_range();
        drive(1, 1, 480, 0);
        tick();
        tests_run += 2;
        if (ram_we !== 1'b0) begin tests_failed++; $display("FAIL oor_col_we got=%b want=0", ram_we); end
        if (ram_addr !== exp_addr) begin tests_failed++; $display("FAIL oor_col_addr got=%h want=%h", ram_addr, exp_addr); end
        drive(1, 1, 484, 0);
        tick();
        drive(1, 1, 0, 272);
        tick();
        tests_run += 3;
        if (pixel_valid !== 1'b0) begin tests_failed++; $display("FAIL oor_col_pv got=%b want=0", pixel_valid); end
        if (pixel !== 4'h0) begin tests_failed++; $display("FAIL oor_col_pix got=%h want=0", pixel); end
        if (ram_addr !== exp_addr) begin tests_failed++; $display("FAIL oor_row_addr got=%h want=%h", ram_addr, exp_addr); end
        drive(1, 1, 4, 272);
        tick();
        drive(0, 0, 0, 0);
        for (int n = 0; n < 4; n++) begin
            tick();
            tests_run += 2;
            if (pixel_valid !== 1'b0) begin tests_failed++; $display("FAIL oor_row_pv n=%0d got=%b want=0", n, pixel_valid); end
            if (pixel !== 4'h0) begin tests_failed++; $display("FAIL oor_row_pix n=%0d got=%h want=0", n, pixel); end
        end
        $display("[TB] test_out_of_range done at cycle %0d", cyc);
    endtask

    task automatic test_reset_mid_write();
        bit got;
        drive(0, 0, 0, 0);
        tick();
        wr_req  = 1'b1;
        wr_addr = 15'h2ABC;
        wr_data = 16'h1234;
        tick();
        rst = 1'b1;
        for (int n = 0; n < 2; n++) begin
            tick();
            tests_run += 3;
            if (ram_we !== 1'b0) begin tests_failed++; $display("FAIL rmw_we n=%0d got=%b want=0", n, ram_we); end
            if (wr_ack !== 1'b0) begin tests_failed++; $display("FAIL rmw_ack n=%0d got=%b want=0", n, wr_ack); end
            if (ram_addr !== 15'h0) begin tests_failed++; $display("FAIL rmw_addr n=%0d got=%h want=0", n, ram_addr); end
        end
        rst = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 3 && !got; n++) begin
            tick();
            if (wr_ack === 1'b1) begin
                got = 1'b1;
                tests_run += 2;
                if (ram_addr !== 15'h2ABC) begin tests_failed++; $display("FAIL rmw_re_addr got=%h want=2ABC", ram_addr); end
                if (ram_wdata !== 16'h1234) begin tests_failed++; $display("FAIL rmw_re_wdata got=%h want=1234", ram_wdata); end
            end
        end
        tests_run++;
        if (!got) begin tests_failed++; $display("FAIL rmw_reack got=none want=ack within 3 cycles"); end
        wr_req = 1'b0;
        tick();
        $display("[TB] test_reset_mid_write done at cycle %0d", cyc);
    endtask

    task automatic test_random();
        int c;
        int r;
        int wait_cnt;
        bit was_rst;
        c        = 0;
        r        = 270;
        wait_cnt = 0;
        for (int i = 0; i < 2500; i++) begin
            hactive = (c < H) || ($urandom % 4 == 0);
            vactive = (r < V) || ($urandom % 4 == 0);
            col     = 12'(c);
            row     = 12'(r);
            if (!wr_req && $urandom % 3 == 0) begin
                wr_req   = 1'b1;
                wr_addr  = 15'($urandom);
                wr_data  = 16'($urandom);
                wait_cnt = 0;
            end
            rst     = ($urandom % 150 == 0);
            was_rst = rst;
            tick();
            tests_run += 6;
            if (ram_we !== exp_we) begin tests_failed++; $display("FAIL rnd_we cyc=%0d got=%b want=%b", cyc, ram_we, exp_we); end
            if (ram_addr !== exp_addr) begin tests_failed++; $display("FAIL rnd_addr cyc=%0d got=%h want=%h", cyc, ram_addr, exp_addr); end
            if (ram_wdata !== exp_wdata) begin tests_failed++; $display("FAIL rnd_wdata cyc=%0d got=%h want=%h", cyc, ram_wdata, exp_wdata); end
            if (wr_ack !== exp_ack) begin tests_failed++; $display("FAIL rnd_ack cyc=%0d got=%b want=%b", cyc, wr_ack, exp_ack); end
            if (pixel_valid !== exp_pv) begin tests_failed++; $display("FAIL rnd_pv cyc=%0d got=%b want=%b", cyc, pixel_valid, exp_pv); end
            if (pixel !== exp_pix) begin tests_failed++; $display("FAIL rnd_pix cyc=%0d got=%h want=%h", cyc, pixel, exp_pix); end
            if (wr_req) begin
                if (wr_ack === 1'b1) begin
                    tests_run++;
                    if (wait_cnt > 2) begin tests_failed++; $display("FAIL rnd_ack_latency cyc=%0d got=%0d want<=3", cyc, wait_cnt + 1); end
                    wr_req   = 1'b0;
                    wait_cnt = 0;
                end else if (was_rst) begin
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                    if (wait_cnt >= 3) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL rnd_ack_timeout cyc=%0d got=no ack want=ack within 3", cyc);
                        wr_req   = 1'b0;
                        wait_cnt = 0;
                    end
                end
            end
            // Occasional column jumps keep the 4-cycle slot phase of a real scan.
            if ($urandom % 50 == 0) c = 4 * $urandom_range(0, 123) + ((c + 1) % 4);
            else c++;
            if (c >= 496) begin
                c = 0;
                r = $urandom_range(266, 276);
            end
        end
        rst    = 1'b0;
        wr_req = 1'b0;
        $display("[TB] test_random done at cycle %0d", cyc);
    endtask

    initial begin
        test_reset();
        test_first_read();
        test_row_col_addr();
        test_write_vs_slot();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
